// File: rtl/rmii_tx_scheduler.sv
// rmii_tx_scheduler
//   Shares one RMII TX channel between NUM_REQ frame sources. Round-robin
//   arbitration, preamble/SFD generation, byte-to-dibit serialisation (LSB pair
//   first) and inter-packet gap. One dibit per sysclk.
//   Optional feature: define RMII_TX_CRC_EN to append a 32-bit FCS (CRC-32,
//   reflected, init all-ones, final invert) after the last payload byte.
module rmii_tx_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int IPG_DIBITS = 48
) (
    input  logic                   sysclk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   tx_byte,
    input  logic [NUM_REQ-1:0]     tx_valid,
    input  logic [NUM_REQ-1:0]     tx_last,
    output logic [NUM_REQ-1:0]     tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [1:0]             ctrl_tx_data,
    output logic                   ctrl_tx_en,
    output logic                   busy,
    output logic                   underrun
);

    localparam int              PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              IW       = $clog2(IPG_DIBITS + 1);
    localparam logic [IW-1:0]   IPG_LAST = IW'(IPG_DIBITS - 1);
    localparam logic [PW-1:0]   IDX_MAX  = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_FCS  = 3'd3,
        ST_IPG  = 3'd4
    } state_t;

`ifdef RMII_TX_CRC_EN
    // Reflected CRC-32 update over one byte, bit 0 first (wire order).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int k = 0; k < 8; k++) begin
            c = (c[0] ^ data[k]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PW-1:0]        r_gidx;
    logic [PW-1:0]        r_ptr;
    logic [4:0]           r_pre_cnt;
    logic [1:0]           r_dib_cnt;
    logic [IW-1:0]        r_ipg_cnt;
    logic [7:0]           r_shift;
    logic                 r_last;
    logic [1:0]           r_tx_data;
    logic                 r_tx_en;
`ifdef RMII_TX_CRC_EN
    logic [31:0]          r_crc;
    logic [31:0]          r_fcs;
    logic [3:0]           r_fcs_cnt;
`endif

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [PW-1:0]        w_gidx_nxt;
    logic [PW-1:0]        w_ptr_nxt;
    logic [4:0]           w_pre_cnt_nxt;
    logic [1:0]           w_dib_cnt_nxt;
    logic [IW-1:0]        w_ipg_cnt_nxt;
    logic [7:0]           w_shift_nxt;
    logic                 w_last_nxt;
    logic [1:0]           w_tx_data_nxt;
    logic                 w_tx_en_nxt;
`ifdef RMII_TX_CRC_EN
    logic [31:0]          w_crc_nxt;
    logic [31:0]          w_fcs_nxt;
    logic [3:0]           w_fcs_cnt_nxt;
`endif

    logic                 w_found_hi;
    logic                 w_found_lo;
    logic [PW-1:0]        w_idx_hi;
    logic [PW-1:0]        w_idx_lo;
    logic [PW-1:0]        w_sel;
    logic [PW-1:0]        w_sel_inc;
    logic [7:0]           w_byte;
    logic                 w_vld;
    logic                 w_lst;
    logic                 w_fetch;
    logic                 w_xfer;
    logic                 w_starve;
    logic                 w_ipg_end;

    // Round-robin pick: first requester at or above the pointer, else the lowest one.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_idx_hi   = {PW{1'b0}};
        w_idx_lo   = {PW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx_hi   = (req[i] && !w_found_hi && (PW'(i) >= r_ptr)) ? PW'(i) : w_idx_hi;
            w_found_hi = w_found_hi | (req[i] && (PW'(i) >= r_ptr));
            w_idx_lo   = (req[i] && !w_found_lo) ? PW'(i) : w_idx_lo;
            w_found_lo = w_found_lo | req[i];
        end
        w_sel     = w_found_hi ? w_idx_hi : w_idx_lo;
        w_sel_inc = (w_sel == IDX_MAX) ? {PW{1'b0}} : (w_sel + PW'(1));
    end

    // Select the byte stream of the granted source.
    always_comb begin
        w_byte = 8'h00;
        w_vld  = 1'b0;
        w_lst  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_byte = (r_gidx == PW'(i)) ? tx_byte[8*i +: 8] : w_byte;
            w_vld  = (r_gidx == PW'(i)) ? tx_valid[i]       : w_vld;
            w_lst  = (r_gidx == PW'(i)) ? tx_last[i]        : w_lst;
        end
    end

    // Byte request points: SFD dibit on the wire, or dibit 3 of a non-last byte.
    always_comb begin
        w_fetch   = ((r_state == ST_PRE) && r_tx_en && (r_pre_cnt == 5'd31)) ||
                    ((r_state == ST_DATA) && (r_dib_cnt == 2'd3) && !r_last);
        w_xfer    = w_fetch && w_vld;
        w_starve  = w_fetch && !w_vld;
        w_ipg_end = (r_state == ST_IPG) && (r_ipg_cnt == IPG_LAST);
    end

    // FSM state register.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = (|req) ? ST_PRE : ST_IDLE;
            end
            ST_PRE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_DATA;
                end else if (w_starve) begin
                    w_state_nxt = ST_IPG;
                end else begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    w_state_nxt = ST_DATA;
                end else if (w_starve) begin
                    w_state_nxt = ST_IPG;
                end else if ((r_dib_cnt == 2'd3) && r_last) begin
`ifdef RMII_TX_CRC_EN
                    w_state_nxt = ST_FCS;
`else
                    w_state_nxt = ST_IPG;
`endif
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_FCS: begin
`ifdef RMII_TX_CRC_EN
                w_state_nxt = (r_fcs_cnt == 4'd15) ? ST_IPG : ST_FCS;
`else
                w_state_nxt = ST_IPG;
`endif
            end
            ST_IPG: begin
                w_state_nxt = w_ipg_end ? ST_IDLE : ST_IPG;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output/datapath decode: next values of the registered wire outputs and counters.
    always_comb begin
        w_grant_nxt   = r_grant;
        w_gidx_nxt    = r_gidx;
        w_ptr_nxt     = r_ptr;
        w_pre_cnt_nxt = r_pre_cnt;
        w_dib_cnt_nxt = r_dib_cnt;
        w_ipg_cnt_nxt = r_ipg_cnt;
        w_shift_nxt   = r_shift;
        w_last_nxt    = r_last;
        w_tx_en_nxt   = 1'b0;
        w_tx_data_nxt = 2'b00;
`ifdef RMII_TX_CRC_EN
        w_crc_nxt     = r_crc;
        w_fcs_nxt     = r_fcs;
        w_fcs_cnt_nxt = r_fcs_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_grant_nxt   = NUM_REQ'(1) << w_sel;
                    w_gidx_nxt    = w_sel;
                    w_ptr_nxt     = w_sel_inc;
                    w_pre_cnt_nxt = 5'd0;
`ifdef RMII_TX_CRC_EN
                    w_crc_nxt     = 32'hFFFF_FFFF;
`endif
                end else begin
                    w_grant_nxt   = {NUM_REQ{1'b0}};
                end
            end
            ST_PRE: begin
                if (!r_tx_en) begin
                    // grant cycle: first preamble dibit goes out next
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = 2'b01;
                    w_pre_cnt_nxt = 5'd0;
                end else if (r_pre_cnt != 5'd31) begin
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = (r_pre_cnt == 5'd30) ? 2'b11 : 2'b01;
                    w_pre_cnt_nxt = r_pre_cnt + 5'd1;
                end else if (w_xfer) begin
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = w_byte[1:0];
                    w_shift_nxt   = {2'b00, w_byte[7:2]};
                    w_dib_cnt_nxt = 2'd0;
                    w_last_nxt    = w_lst;
`ifdef RMII_TX_CRC_EN
                    w_crc_nxt     = crc32_byte(r_crc, w_byte);
`endif
                end else begin
                    w_ipg_cnt_nxt = {IW{1'b0}};
                end
            end
            ST_DATA: begin
                if (r_dib_cnt != 2'd3) begin
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = r_shift[1:0];
                    w_shift_nxt   = {2'b00, r_shift[7:2]};
                    w_dib_cnt_nxt = r_dib_cnt + 2'd1;
                end else if (r_last) begin
`ifdef RMII_TX_CRC_EN
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = ~r_crc[1:0];
                    w_fcs_nxt     = {2'b00, ~r_crc[31:2]};
                    w_fcs_cnt_nxt = 4'd0;
`else
                    w_ipg_cnt_nxt = {IW{1'b0}};
`endif
                end else if (w_xfer) begin
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = w_byte[1:0];
                    w_shift_nxt   = {2'b00, w_byte[7:2]};
                    w_dib_cnt_nxt = 2'd0;
                    w_last_nxt    = w_lst;
`ifdef RMII_TX_CRC_EN
                    w_crc_nxt     = crc32_byte(r_crc, w_byte);
`endif
                end else begin
                    // starved: truncate, no FCS
                    w_ipg_cnt_nxt = {IW{1'b0}};
                end
            end
            ST_FCS: begin
`ifdef RMII_TX_CRC_EN
                if (r_fcs_cnt != 4'd15) begin
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = r_fcs[1:0];
                    w_fcs_nxt     = {2'b00, r_fcs[31:2]};
                    w_fcs_cnt_nxt = r_fcs_cnt + 4'd1;
                end else begin
                    w_ipg_cnt_nxt = {IW{1'b0}};
                end
`else
                w_ipg_cnt_nxt = {IW{1'b0}};
`endif
            end
            ST_IPG: begin
                if (w_ipg_end) begin
                    w_grant_nxt   = {NUM_REQ{1'b0}};
                end else begin
                    w_ipg_cnt_nxt = r_ipg_cnt + IW'(1);
                end
            end
            default: begin
                w_grant_nxt = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // Datapath registers; reset clears the wire immediately (no partial tail).
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant   <= {NUM_REQ{1'b0}};
            r_gidx    <= {PW{1'b0}};
            r_ptr     <= {PW{1'b0}};
            r_pre_cnt <= 5'd0;
            r_dib_cnt <= 2'd0;
            r_ipg_cnt <= {IW{1'b0}};
            r_shift   <= 8'h00;
            r_last    <= 1'b0;
            r_tx_data <= 2'b00;
            r_tx_en   <= 1'b0;
`ifdef RMII_TX_CRC_EN
            r_crc     <= 32'h0000_0000;
            r_fcs     <= 32'h0000_0000;
            r_fcs_cnt <= 4'd0;
`endif
        end else begin
            r_grant   <= w_grant_nxt;
            r_gidx    <= w_gidx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_dib_cnt <= w_dib_cnt_nxt;
            r_ipg_cnt <= w_ipg_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_last    <= w_last_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_en   <= w_tx_en_nxt;
`ifdef RMII_TX_CRC_EN
            r_crc     <= w_crc_nxt;
            r_fcs     <= w_fcs_nxt;
            r_fcs_cnt <= w_fcs_cnt_nxt;
`endif
        end
    end

    assign grant        = r_grant;
    assign ctrl_tx_data = r_tx_data;
    assign ctrl_tx_en   = r_tx_en;
    assign busy         = (r_state != ST_IDLE);
    assign underrun     = w_starve;
    assign tx_ready     = r_grant & {NUM_REQ{w_fetch}};

endmodule
